// File: rtl/imm_gen_pkg.sv
// Shared widths, format encodings and the request bundle for the immediate generator.
package imm_gen_pkg;

    localparam int IMM_W   = 25;  // instruction bits [31:7]
    localparam int IMM32_W = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_fmt_e;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        logic [2:0]       funct;
    } imm_req_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational format decode: raw instruction bits [31:7] to a 32-bit immediate.
module imm_decode
    import imm_gen_pkg::*;
(
    input  logic [IMM_W-1:0]   immediate,
    input  logic [2:0]         funct,
    output logic [IMM32_W-1:0] imm32
);

    logic sgn;
    assign sgn = immediate[24];

    // Reassemble the immediate per format; unknown codes decode to zero.
    always_comb begin
        imm32 = '0;
        case (funct)
            IMM_I: imm32 = {{20{sgn}}, immediate[24:13]};
            IMM_S: imm32 = {{20{sgn}}, immediate[24:18], immediate[4:0]};
            IMM_B: imm32 = {{19{sgn}}, sgn, immediate[0], immediate[23:18],
                            immediate[4:1], 1'b0};
            IMM_U: imm32 = {immediate[24:5], 12'b0};
            IMM_J: imm32 = {{11{sgn}}, sgn, immediate[12:5], immediate[13],
                            immediate[23:14], 1'b0};
            default: imm32 = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen.sv
// Immediate generator: one-cycle registered decode with a valid flag.
module imm_gen
    import imm_gen_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IMM_W-1:0]   immediate,
    input  logic [2:0]         funct,
    input  logic               in_valid,
    output logic [IMM32_W-1:0] imm32,
    output logic               out_valid
);

    imm_req_t           req;
    logic [IMM32_W-1:0] dec;

    assign req = '{imm: immediate, funct: funct};

    imm_decode u_dec (
        .immediate (req.imm),
        .funct     (req.funct),
        .imm32     (dec)
    );

    // Capture the decoded value on accepted input; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm32 <= '0;
        end else if (in_valid) begin
            imm32 <= dec;
        end
    end

    // Valid follows the input by exactly one edge; no backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_imm_gen.sv
// Directed self-checking bench for imm_gen.
module tb_imm_gen;

    logic        clk;
    logic        rst_n;
    logic [24:0] immediate;
    logic [2:0]  funct;
    logic        in_valid;
    logic [31:0] imm32;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    imm_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .immediate (immediate),
        .funct     (funct),
        .in_valid  (in_valid),
        .imm32     (imm32),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, then sample just after the next rising edge.
    task automatic step(input logic [24:0] im, input logic [2:0] f, input logic v);
        @(negedge clk);
        immediate = im;
        funct     = f;
        in_valid  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string tag, input logic [24:0] im, input logic [2:0] f,
                      input logic [31:0] exp);
        step(im, f, 1'b1);
        chk32(tag, imm32, exp);
        chk1({tag, "_v"}, out_valid, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        immediate = '0;
        funct     = '0;
        in_valid  = 1'b0;
        #3;
        chk32("rst_imm", imm32, 32'h0);
        chk1("rst_vld", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Spec vectors
        op("i_pos", 25'b0_11111111111_0001000000001, 3'b000, 32'h0000_07FF);
        op("i_neg", 25'b1_00000000000_0001000000001, 3'b000, 32'hFFFF_F800);
        op("s",     25'b0000011000010001000000100,   3'b001, 32'h0000_0064);
        op("b",     25'b0000000001100010100011110,   3'b010, 32'h0000_001E);
        op("j",     25'b0000000111100000000001001,   3'b100, 32'h0000_001E);
        op("u",     25'h1FF_FFFF,                    3'b011, 32'hFFFF_F000);

        // Sign extension and bit placement corners
        op("i_ones", 25'h1FF_FFFF, 3'b000, 32'hFFFF_FFFF);
        op("s_ones", 25'h1FF_FFFF, 3'b001, 32'hFFFF_FFFF);
        op("b_ones", 25'h1FF_FFFF, 3'b010, 32'hFFFF_FFFE);
        op("j_ones", 25'h1FF_FFFF, 3'b100, 32'hFFFF_FFFE);
        op("b_bit11", 25'h000_0001, 3'b010, 32'h0000_0800);  // instr[7] -> imm[11]
        op("j_bit11", 25'h000_2000, 3'b100, 32'h0000_0800);  // instr[20] -> imm[11]
        op("j_hi",    25'h000_1FE0, 3'b100, 32'h000F_F000);  // instr[19:12]
        op("u_low",   25'h000_0020, 3'b011, 32'h0000_1000);
        op("unsup101", 25'h1FF_FFFF, 3'b101, 32'h0000_0000);
        op("unsup110", 25'h1FF_FFFF, 3'b110, 32'h0000_0000);

        // Unsupported code then hold
        op("unsup111", 25'h1FF_FFFF, 3'b111, 32'h0000_0000);
        for (int k = 0; k < 3; k++) begin
            step(25'h1FF_FFFF, 3'b000, 1'b0);
            chk32("hold0_imm", imm32, 32'h0);
            chk1("hold0_vld", out_valid, 1'b0);
        end

        // Hold a nonzero value while inputs keep changing
        op("pre_hold", 25'h000_2000, 3'b000, 32'h0000_0001);
        for (int k = 0; k < 3; k++) begin
            step(25'h1FF_FFFF, 3'b011, 1'b0);
            chk32("hold1_imm", imm32, 32'h0000_0001);
            chk1("hold1_vld", out_valid, 1'b0);
        end

        // Asynchronous reset between edges
        op("pre_rst", 25'b1_00000000000_0001000000001, 3'b000, 32'hFFFF_F800);
        #2;
        rst_n = 1'b0;
        #1;
        chk32("arst_imm", imm32, 32'h0);
        chk1("arst_vld", out_valid, 1'b0);
        // An edge during reset with in_valid high must not load
        immediate = 25'h1FF_FFFF;
        funct     = 3'b000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        chk32("inrst_imm", imm32, 32'h0);
        chk1("inrst_vld", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        op("post_rst", 25'b0_11111111111_0001000000001, 3'b000, 32'h0000_07FF);
        step(25'h0, 3'b000, 1'b0);
        chk1("post_idle_vld", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
